// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: owns the branch predictor write port.
// After reset or flush it walks every BTB entry with an invalidate strobe.
// Once the walk is done it arbitrates two resolution lanes into a small
// update queue, which drains one entry per cycle into the predictor.
// While the BTB is invalid, fetch prediction falls back to PC+4.
module bp_update_ctrl #(
  parameter int FIFO_DEPTH  = 4,
  parameter int BTB_ENTRIES = 64,
  parameter int IDX_W       = $clog2(BTB_ENTRIES)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_pc,
  input  logic [31:0]      req0_target,
  input  logic             req0_taken,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_pc,
  input  logic [31:0]      req1_target,
  input  logic             req1_taken,
  input  logic             flush_req,
  input  logic             bp_wr_hold,
  output logic             bp_wr_en,
  output logic             bp_is_taken,
  output logic [31:0]      bp_update_pc,
  output logic [31:0]      bp_update_target_pc,
  output logic             bp_inv_en,
  output logic [IDX_W-1:0] bp_inv_idx,
  input  logic [31:0]      fetch_pc,
  output logic [31:0]      bp_current_pc,
  input  logic [31:0]      bp_predicted_pc,
  output logic [31:0]      pred_pc,
  output logic             busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BTB_ENTRIES - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] inv_idx_q, inv_idx_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             rr_ptr_q, rr_ptr_d;

  logic [31:0] pc_q  [FIFO_DEPTH];
  logic [31:0] tgt_q [FIFO_DEPTH];
  logic        tkn_q [FIFO_DEPTH];

  logic        run;
  logic        can_acc;
  logic        grant0, grant1;
  logic        push, pop;
  logic [31:0] wr_pc, wr_tgt;
  logic        wr_tkn;

  // Arbitration and drain decisions for the current cycle.
  always_comb begin
    run     = (state_q == S_RUN);
    // A full queue never accepts, even if it pops this cycle.
    can_acc = run & ~flush_req & (count_q != CNT_FULL);
    grant0  = can_acc & req0_valid & (~req1_valid | ~rr_ptr_q);
    grant1  = can_acc & req1_valid & (~req0_valid |  rr_ptr_q);
    push    = grant0 | grant1;
    pop     = run & (count_q != '0) & ~bp_wr_hold;
    wr_pc   = grant1 ? req1_pc     : req0_pc;
    wr_tgt  = grant1 ? req1_target : req0_target;
    wr_tkn  = grant1 ? req1_taken  : req0_taken;
  end

  // Next-state logic for the walk, the queue pointers and the round-robin pointer.
  always_comb begin
    state_d   = state_q;
    inv_idx_d = inv_idx_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    rr_ptr_d  = rr_ptr_q;
    case (state_q)
      S_INIT: begin
        if (flush_req) begin
          inv_idx_d = '0;
        end else if (inv_idx_q == IDX_LAST) begin
          state_d   = S_RUN;
          inv_idx_d = '0;
        end else begin
          inv_idx_d = inv_idx_q + 1'b1;
        end
      end
      default: begin
        if (flush_req) begin
          state_d   = S_INIT;
          inv_idx_d = '0;
          rd_ptr_d  = '0;
          wr_ptr_d  = '0;
          count_d   = '0;
        end else begin
          if (push) wr_ptr_d = wr_ptr_q + 1'b1;
          if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
          case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
          endcase
          // Only a contested grant moves the fairness pointer.
          if (push && req0_valid && req1_valid) rr_ptr_d = ~rr_ptr_q;
        end
      end
    endcase
  end

  // State registers and queue storage; storage is cleared on reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_INIT;
      inv_idx_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      rr_ptr_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_q[i]  <= '0;
        tgt_q[i] <= '0;
        tkn_q[i] <= 1'b0;
      end
    end else begin
      state_q   <= state_d;
      inv_idx_q <= inv_idx_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      rr_ptr_q  <= rr_ptr_d;
      if (push) begin
        pc_q[wr_ptr_q]  <= wr_pc;
        tgt_q[wr_ptr_q] <= wr_tgt;
        tkn_q[wr_ptr_q] <= wr_tkn;
      end
    end
  end

  // Output decode: head of queue to the predictor, walk status, prediction gating.
  always_comb begin
    req0_ready          = grant0;
    req1_ready          = grant1;
    bp_wr_en            = pop;
    bp_is_taken         = tkn_q[rd_ptr_q];
    bp_update_pc        = pc_q[rd_ptr_q];
    bp_update_target_pc = tgt_q[rd_ptr_q];
    busy                = ~run;
    bp_inv_en           = ~run;
    bp_inv_idx          = inv_idx_q;
    bp_current_pc       = fetch_pc;
    pred_pc             = busy ? (fetch_pc + 32'd4) : bp_predicted_pc;
  end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Testbench for bp_update_ctrl: a cycle-level reference model predicts
// readies, walk status and prediction outputs, and queues expected predictor
// writes; a separate monitor pops that queue whenever the DUT writes.
module tb_bp_update_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        req0_valid, req0_ready, req0_taken;
  logic [31:0] req0_pc, req0_target;
  logic        req1_valid, req1_ready, req1_taken;
  logic [31:0] req1_pc, req1_target;
  logic        flush_req, bp_wr_hold;
  logic        bp_wr_en, bp_is_taken;
  logic [31:0] bp_update_pc, bp_update_target_pc;
  logic        bp_inv_en;
  logic [5:0]  bp_inv_idx;
  logic [31:0] fetch_pc, bp_current_pc, bp_predicted_pc, pred_pc;
  logic        busy;

  bp_update_ctrl #(.FIFO_DEPTH(4), .BTB_ENTRIES(64)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_pc(req0_pc),
    .req0_target(req0_target), .req0_taken(req0_taken),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_pc(req1_pc),
    .req1_target(req1_target), .req1_taken(req1_taken),
    .flush_req(flush_req), .bp_wr_hold(bp_wr_hold),
    .bp_wr_en(bp_wr_en), .bp_is_taken(bp_is_taken),
    .bp_update_pc(bp_update_pc), .bp_update_target_pc(bp_update_target_pc),
    .bp_inv_en(bp_inv_en), .bp_inv_idx(bp_inv_idx),
    .fetch_pc(fetch_pc), .bp_current_pc(bp_current_pc),
    .bp_predicted_pc(bp_predicted_pc), .pred_pc(pred_pc), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tkn;
  } ent_t;

  ent_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: predictor is either walking (m_walk counts entries) or
  // running with m_cnt pending updates and a fairness pointer m_rr.
  bit   m_run = 0;
  int   m_walk = 0;
  bit   m_rr = 0;
  int   m_cnt = 0;
  bit   last_g0, last_g1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", nm, act, expv, $time);
    end
  endtask

  // One cycle: called at a falling edge with inputs already driven.
  task automatic tick();
    bit e_r0, e_r1, e_we, can, both;
    #2;
    e_r0 = 0; e_r1 = 0; e_we = 0;
    if (RST) begin
      chk("rst_busy", busy, 1);
      chk("rst_inv_en", bp_inv_en, 1);
      chk("rst_inv_idx", bp_inv_idx, 0);
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_wr_en", bp_wr_en, 0);
      chk("rst_pred_pc", pred_pc, fetch_pc + 32'd4);
      m_run = 0; m_walk = 0; m_rr = 0; m_cnt = 0;
      exp_q.delete();
      last_g0 = 0; last_g1 = 0;
    end else begin
      if (m_run) begin
        can  = !flush_req && (m_cnt < 4);
        both = req0_valid && req1_valid;
        e_r0 = can && req0_valid && (!req1_valid || !m_rr);
        e_r1 = can && req1_valid && (!req0_valid || m_rr);
        e_we = (m_cnt != 0) && !bp_wr_hold;
      end
      chk("busy", busy, !m_run);
      chk("inv_en", bp_inv_en, !m_run);
      if (!m_run) chk("inv_idx", bp_inv_idx, m_walk);
      chk("ready0", req0_ready, e_r0);
      chk("ready1", req1_ready, e_r1);
      chk("wr_en", bp_wr_en, e_we);
      chk("current_pc", bp_current_pc, fetch_pc);
      chk("pred_pc", pred_pc, m_run ? bp_predicted_pc : fetch_pc + 32'd4);
      last_g0 = e_r0; last_g1 = e_r1;
      if (!m_run) begin
        if (flush_req) m_walk = 0;
        else if (m_walk == 63) begin m_run = 1; m_walk = 0; end
        else m_walk++;
      end else if (flush_req) begin
        m_run = 0; m_walk = 0; m_cnt = 0;
        exp_q.delete();
      end else begin
        if (e_r0) exp_q.push_back('{req0_pc, req0_target, req0_taken});
        if (e_r1) exp_q.push_back('{req1_pc, req1_target, req1_taken});
        if ((e_r0 || e_r1) && both) m_rr = !m_rr;
        m_cnt = m_cnt + int'(e_r0 || e_r1) - int'(e_we);
      end
    end
    @(negedge CLK);
  endtask

  // Monitor: every DUT write must match the oldest outstanding expected update.
  initial begin
    ent_t e;
    forever begin
      @(negedge CLK);
      #1;
      if (bp_wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write actual pc=0x%08h required no write t=%0t", bp_update_pc, $time);
        end else begin
          e = exp_q.pop_front();
          chk("wr_pc", bp_update_pc, e.pc);
          chk("wr_target", bp_update_target_pc, e.tgt);
          chk("wr_taken", bp_is_taken, e.tkn);
        end
      end
    end
  end

  initial begin
    int n;
    req0_valid = 0; req0_pc = 0; req0_target = 0; req0_taken = 0;
    req1_valid = 0; req1_pc = 0; req1_target = 0; req1_taken = 0;
    flush_req = 0; bp_wr_hold = 0;
    fetch_pc = 32'h100; bp_predicted_pc = 32'hCAFE0000;
    #1 RST = 1;
    @(negedge CLK);
    tick(); tick();
    RST = 0;

    // Initial walk; one cycle probes the +4 wrap.
    for (int i = 0; i < 64; i++) begin
      fetch_pc = (i == 30) ? 32'hFFFFFFFC : 32'h100;
      tick();
    end
    fetch_pc = 32'h100;
    tick();

    // Single lane-0 update.
    req0_valid = 1; req0_pc = 32'h200; req0_target = 32'h280; req0_taken = 1;
    tick();
    req0_valid = 0;
    repeat (3) tick();

    // Both lanes contending: grants alternate.
    req0_valid = 1; req0_pc = 32'h10; req0_target = 32'h20; req0_taken = 0;
    req1_valid = 1; req1_pc = 32'h30; req1_target = 32'h40; req1_taken = 1;
    repeat (4) tick();
    req0_valid = 0; req1_valid = 0;
    repeat (4) tick();

    // Held write port: queue fills at 4, fifth waits until space frees.
    bp_wr_hold = 1; req0_valid = 1; req0_taken = 1; n = 0;
    for (int c = 0; c < 30 && n < 5; c++) begin
      if (c == 8) bp_wr_hold = 0;
      req0_pc = 32'h1000 + n * 4; req0_target = 32'h2000 + n * 4;
      tick();
      if (last_g0) n++;
    end
    chk("hold_accepted", n, 5);
    req0_valid = 0; bp_wr_hold = 0;
    repeat (6) tick();

    // Flush with three queued updates: none may reach the predictor.
    bp_wr_hold = 1; req1_valid = 1;
    for (int i = 0; i < 3; i++) begin
      req1_pc = 32'h3000 + i * 4; req1_target = 32'h3100 + i; req1_taken = i[0];
      tick();
    end
    req1_valid = 0; req0_valid = 1; req0_pc = 32'h4000;
    flush_req = 1;
    tick();
    flush_req = 0; req0_valid = 0; bp_wr_hold = 0;

    // Reset in the middle of the walk, then a full walk again.
    for (int c = 0; c < 40 && m_walk != 20; c++) tick();
    chk("walk_reached_20", bp_inv_idx, 20);
    RST = 1;
    tick();
    RST = 0;
    repeat (66) tick();

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 500; c++) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_pc = $urandom; req0_target = $urandom; req0_taken = $urandom_range(0, 1);
      req1_pc = $urandom; req1_target = $urandom; req1_taken = $urandom_range(0, 1);
      bp_wr_hold = ($urandom_range(0, 3) == 0);
      flush_req = ($urandom_range(0, 59) == 0);
      fetch_pc = $urandom; bp_predicted_pc = $urandom;
      tick();
    end
    req0_valid = 0; req1_valid = 0; bp_wr_hold = 0; flush_req = 0;
    for (int c = 0; c < 80 && (m_cnt != 0 || !m_run); c++) tick();
    repeat (2) tick();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_update_ctrl.md
Name: bp_update_ctrl

Overview:
- Sequences all writes into the branch predictor (BTB) write port.
- After reset or a flush request, it walks and invalidates every BTB entry.
- Afterwards it round-robin arbitrates two branch-resolution requesters into a small update FIFO, which it drains one entry per cycle into the predictor's is_taken / Wr_enable / update_PC / update_target_PC inputs.
- It also gates the fetch-side prediction while the BTB contents are invalid.

Parameters:
- FIFO_DEPTH, 4, update queue entries (power of 2, ≥2)
- BTB_ENTRIES, 64, predictor entries to invalidate (power of 2)
- IDX_W, $clog2(BTB_ENTRIES), invalidate index width

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- req0_valid  in  1  lane 0 resolution valid
- req0_ready  out  1  lane 0 accepted this cycle
- req0_pc  in  32  lane 0 branch PC
- req0_target  in  32  lane 0 resolved target
- req0_taken  in  1  lane 0 resolved direction
- req1_valid / req1_ready / req1_pc / req1_target / req1_taken  same widths, lane 1
- flush_req  in  1  single-cycle request to clear queue and BTB
- bp_wr_hold  in  1  predictor write port unavailable this cycle
- bp_wr_en  out  1  drives Wr_enable
- bp_is_taken  out  1  drives is_taken
- bp_update_pc  out  32  drives update_PC
- bp_update_target_pc  out  32  drives update_target_PC
- bp_inv_en  out  1  invalidate strobe
- bp_inv_idx  out  IDX_W  entry being invalidated
- fetch_pc  in  32  fetch lookup PC
- bp_current_pc  out  32  drives current_PC
- bp_predicted_pc  in  32  predicted_PC from predictor
- pred_pc  out  32  next fetch PC to fetch stage
- busy  out  1  high while in INIT

Behaviour:
- FSM states:
  - INIT: invalidate walk.
  - RUN: normal operation.
- Async RST:
  - state=INIT, inv_idx=0, FIFO count/rd/wr pointers=0, rr_ptr=0 (lane 0 favoured).
  - All FIFO entry fields are cleared to 0.
  - All outputs follow from this state; bp_inv_en=1 and busy=1 while RST is held.
- INIT:
  - bp_inv_en=1 and bp_inv_idx=inv_idx every cycle; inv_idx increments each cycle.
  - When inv_idx==BTB_ENTRIES-1 the next state is RUN and inv_idx wraps to 0. The walk therefore takes exactly BTB_ENTRIES cycles and is not affected by bp_wr_hold.
  - bp_wr_en=0, both readies=0.
  - flush_req in INIT restarts the walk: inv_idx=0 on the next edge.
- RUN:
  - bp_inv_en=0, busy=0.
  - flush_req=1 on an edge: FIFO is emptied (pointers and count reset), inv_idx=0, next state INIT. Requests presented in the same cycle are not accepted (both readies=0 while flush_req=1).
- Arbitration (RUN, no flush, count<FIFO_DEPTH), combinational:
  - Only one valid: that lane is granted.
  - Both valid: the lane at rr_ptr is granted, and rr_ptr toggles to the other lane on that edge.
  - A single-lane grant leaves rr_ptr unchanged.
  - reqN_ready = grantN.
  - The granted entry {pc, target, taken} is written at wr_ptr on the edge.
  - count==FIFO_DEPTH forces both readies=0.
  - Requester valid must not depend on ready.
- Drain (RUN, combinational from FIFO head):
  - bp_wr_en = (count!=0) & ~bp_wr_hold.
  - bp_update_pc / bp_update_target_pc / bp_is_taken are the head fields.
  - The head pops on the edge when bp_wr_en=1.
- Count rules:
  - Enqueue and pop in the same cycle: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - No full-bypass: a full queue does not accept, even while popping.
- Latency: a request accepted at edge N into an empty queue drives bp_wr_en during the following cycle (1-cycle), unless held.
- Prediction:
  - bp_current_pc = fetch_pc (passthrough).
  - pred_pc = busy ? fetch_pc+32'd4 : bp_predicted_pc. The +4 wraps mod 2^32.
- Order: updates reach the predictor in acceptance order. An update to an entry after a flush is never lost, because the queue is only refilled after the walk ends.

Test Plan:
- Release RST, no requests → bp_inv_en=1 with bp_inv_idx 0..63 over 64 cycles, busy=1, readies=0, pred_pc=fetch_pc+4 (fetch_pc=0x100 → 0x104). Cycle 65: busy=0, pred_pc=bp_predicted_pc.
- RUN, req0 {pc=0x200, target=0x280, taken=1} for one cycle → req0_ready=1. The next cycle shows bp_wr_en=1, bp_update_pc=0x200, bp_update_target_pc=0x280, bp_is_taken=1, then bp_wr_en=0.
- Both lanes valid for 4 cycles with distinct PCs 0x10/0x20 (lane0), 0x30/0x40 (lane1) → grants alternate lane0, lane1, lane0, lane1. Writes emerge in that order, one per cycle.
- bp_wr_hold=1 and 5 requests on lane 0 → 4 accepted, then req0_ready=0. Drop hold → 4 writes in order, then the 5th is accepted and written.
- Queue holding 3 entries, pulse flush_req → next cycle count=0, busy=1, the walk restarts at idx 0, and no queued write appears on bp_wr_en.
- Assert RST at walk index 20 → outputs reset immediately. After release the walk restarts at idx 0 and lasts a full 64 cycles.
